// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 4-digit multiplexed 7-segment driver with blanking and frame snapshot
module seven_segment_scanner #(
    parameter int SCAN_PERIOD  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] twoByteInput,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [1:0]  digit_index,
    output logic        frame_done
);
    localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        wrap, frame_end;
    logic [3:0]  nibble;
    logic [3:0]  lz_hide;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign wrap      = (cnt_q == CW'(SCAN_PERIOD - 1));
    assign frame_end = wrap && (dig_q == 2'd3);
    assign nibble    = shadow_q[{dig_q, 2'b00} +: 4];

    // A digit hides only while it and every more-significant digit are zero.
    assign lz_hide[3] = lz_blank && (shadow_q[15:12] == 4'd0);
    assign lz_hide[2] = lz_hide[3] && (shadow_q[11:8] == 4'd0);
    assign lz_hide[1] = lz_hide[2] && (shadow_q[7:4] == 4'd0);
    assign lz_hide[0] = 1'b0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        shadow_d = shadow_q;
        anode_d  = 4'b1111;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            dig_d = wrap ? dig_q + 2'd1 : dig_q;
            if (frame_end) begin
                shadow_d = twoByteInput;
            end
            case (state_q)
                BLANK:   if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = SHOW;
                SHOW:    if (wrap) state_d = BLANK;
                default: state_d = BLANK;
            endcase
            if (state_q == SHOW) begin
                anode_d = ~(4'b0001 << dig_q);
                seg_d   = lz_hide[dig_q] ? 7'h7F : decode(nibble);
                dp_d    = ~dp_mask[dig_q];
            end
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q  <= BLANK;
            cnt_q    <= '0;
            dig_q    <= 2'd0;
            shadow_q <= 16'h0000;
            anode_q  <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            anode_q  <= anode_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign anode       = anode_q;
    assign segments    = seg_q;
    assign dp          = dp_q;
    assign digit_index = dig_q;
    assign frame_done  = enable && !reset && frame_end;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner
module tb_seven_segment_scanner;
    localparam int SP = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] din = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dp;
    logic [1:0]  digit_index;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seven_segment_scanner #(.SCAN_PERIOD(SP), .BLANK_CYCLES(BC)) dut (
        .qzt_clk(clk), .reset(reset), .enable(enable), .twoByteInput(din),
        .dp_mask(dp_mask), .lz_blank(lz_blank), .anode(anode), .segments(segments),
        .dp(dp), .digit_index(digit_index), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] di;
    } exp_t;

    exp_t sbq[$];
    int   m_cnt = 0;
    int   m_dig = 0;
    logic [15:0] m_shadow = 16'h0000;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (n > 4'd9) return 7'b0111111;
        return tab[n];
    endfunction

    // Reference model: next registered outputs from the pre-edge model state.
    always @(posedge clk) begin
        exp_t e;
        int   msd;
        logic [3:0] nib;
        e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1;
        if (reset) begin
            m_cnt = 0; m_dig = 0; m_shadow = 16'h0000;
        end else begin
            if (enable && m_cnt >= BC) begin
                msd = 0;
                for (int k = 0; k < 4; k++) if (m_shadow[k*4 +: 4] != 4'd0) msd = k;
                nib = m_shadow[m_dig*4 +: 4];
                e.an  = 4'b1111;
                e.an[m_dig] = 1'b0;
                e.seg = (lz_blank && m_dig > msd) ? 7'h7F : seg_of(nib);
                e.dp  = ~dp_mask[m_dig];
            end
            if (enable) begin
                if (m_cnt == SP - 1) begin
                    if (m_dig == 3) m_shadow = din;
                    m_cnt = 0;
                    m_dig = (m_dig + 1) % 4;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        e.di = 2'(m_dig);
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sb_anode", 16'(anode), 16'(e.an));
            check("sb_seg", 16'(segments), 16'(e.seg));
            check("sb_dp", 16'(dp), 16'(e.dp));
            check("sb_digit", 16'(digit_index), 16'(e.di));
            check("sb_frame_done", 16'(frame_done),
                  16'(enable && !reset && m_cnt == SP - 1 && m_dig == 3));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at cycle 0 of the next frame (cnt=0, digit 0).
    task automatic wait_frame();
        int n = 0;
        while (!frame_done && n < 100) begin
            tick();
            n++;
        end
        if (!frame_done) check("frame_timeout", 16'd0, 16'd1);
        tick();
    endtask

    initial begin
        int n;
        tick(3);
        check("rst_anode", 16'(anode), 16'hF);
        check("rst_seg", 16'(segments), 16'h7F);
        check("rst_dp", 16'(dp), 16'h1);
        check("rst_digit", 16'(digit_index), 16'h0);
        check("rst_frame_done", 16'(frame_done), 16'h0);
        reset = 1'b0;

        din = 16'h1234;
        wait_frame();
        tick(1);
        check("t2_blank_an", 16'(anode), 16'hF);
        tick(4);
        check("t2_d0_an", 16'(anode), 16'b1110);
        check("t2_d0_seg", 16'(segments), 16'b0011001);
        tick(8);
        check("t2_d1_an", 16'(anode), 16'b1101);
        check("t2_d1_seg", 16'(segments), 16'b0110000);
        tick(8);
        check("t2_d2_an", 16'(anode), 16'b1011);
        check("t2_d2_seg", 16'(segments), 16'b0100100);
        tick(8);
        check("t2_d3_an", 16'(anode), 16'b0111);
        check("t2_d3_seg", 16'(segments), 16'b1111001);

        din = 16'h0070;
        lz_blank = 1'b1;
        wait_frame();
        tick(5);
        check("t3_d0_seg", 16'(segments), 16'b1000000);
        tick(8);
        check("t3_d1_seg", 16'(segments), 16'b1111000);
        tick(8);
        check("t3_d2_seg", 16'(segments), 16'h7F);
        check("t3_d2_an", 16'(anode), 16'b1011);
        tick(8);
        check("t3_d3_seg", 16'(segments), 16'h7F);

        din = 16'h00A0;
        lz_blank = 1'b0;
        dp_mask = 4'b0010;
        wait_frame();
        tick(5);
        check("t4_d0_dp", 16'(dp), 16'h1);
        tick(8);
        check("t4_d1_seg", 16'(segments), 16'b0111111);
        check("t4_d1_dp", 16'(dp), 16'h0);
        tick(8);
        check("t4_d2_dp", 16'(dp), 16'h1);

        din = 16'h1111;
        dp_mask = 4'b0000;
        wait_frame();
        tick(10);
        din = 16'h2222;
        tick(3);
        check("t5_old_d1", 16'(segments), 16'b1111001);
        tick(16);
        check("t5_old_d3", 16'(segments), 16'b1111001);
        wait_frame();
        tick(5);
        check("t5_new_d0", 16'(segments), 16'b0100100);

        tick(15);
        check("t6_digit", 16'(digit_index), 16'd2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_dark", 16'(anode), 16'hF);
        end
        enable = 1'b1;
        check("t6_held_digit", 16'(digit_index), 16'd2);
        tick();
        check("t6_resume_an", 16'(anode), 16'b1011);
        n = 0;
        while (digit_index != 2'd3 && n < 50) begin
            tick();
            n++;
        end
        if (digit_index != 2'd3) check("t6_timeout", 16'd0, 16'd1);
        tick(3);
        reset = 1'b1;
        tick();
        check("t6_rst_digit", 16'(digit_index), 16'd0);
        check("t6_rst_an", 16'(anode), 16'hF);
        reset = 1'b0;
        tick();
        check("t6_restart_an", 16'(anode), 16'hF);
        check("t6_restart_digit", 16'(digit_index), 16'd0);
        tick(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
